// File: rtl/barrel_shl_pipe_16bit_if.sv
// Producer/consumer handshake bundle for the pipelined 16-bit left barrel shifter.
// out_ovf exists only when BARREL_SHL_OVF_EN is defined.
interface barrel_shl_pipe_16bit_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_amt;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
`ifdef BARREL_SHL_OVF_EN
  logic        out_ovf;

  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data, out_ovf
  );
  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data, out_ovf
  );
`else
  modport master (
    output in_valid, in_data, in_amt, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_amt, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/barrel_shl_pipe_16bit.sv
// Four-stage pipelined 16-bit logical left shifter (8/4/2/1), valid/ready on both sides.
// Optional sticky overflow flag on out_ovf when BARREL_SHL_OVF_EN is defined.
module barrel_shl_pipe_16bit #(
  parameter int WIDTH          = 16,
  parameter bit STAGE_RST_DATA = 1'b0
) (
  input logic clk,
  input logic rst,
  barrel_shl_pipe_16bit_if.slave bus
);

  logic             v0_r, v1_r, v2_r, v3_r;
  logic [WIDTH-1:0] d0_r, d1_r, d2_r, d3_r;
  logic [2:0]       a0_r;
  logic [1:0]       a1_r;
  logic             a2_r;
  logic             rdy0_s, rdy1_s, rdy2_s, rdy3_s;
  logic [WIDTH-1:0] sh0_s, sh1_s, sh2_s, sh3_s;
`ifdef BARREL_SHL_OVF_EN
  logic             ovf0_r, ovf1_r, ovf2_r, ovf3_r;
  logic             ovf0_s, ovf1_s, ovf2_s, ovf3_s;
`endif

  // Ready chain: a stage can load if it is empty or its successor loads this edge.
  always_comb begin
    rdy3_s = ~v3_r | bus.out_ready;
    rdy2_s = ~v2_r | rdy3_s;
    rdy1_s = ~v1_r | rdy2_s;
    rdy0_s = ~v0_r | rdy1_s;
  end

  // Per-stage shift of 8/4/2/1 selected by the amount bit owned by that stage.
  always_comb begin
    sh0_s = bus.in_data;
    sh1_s = d0_r;
    sh2_s = d1_r;
    sh3_s = d2_r;
    if (bus.in_amt[3]) begin
      sh0_s = {bus.in_data[7:0], 8'h00};
    end else begin
      sh0_s = bus.in_data;
    end
    if (a0_r[2]) begin
      sh1_s = {d0_r[11:0], 4'h0};
    end else begin
      sh1_s = d0_r;
    end
    if (a1_r[1]) begin
      sh2_s = {d1_r[13:0], 2'b00};
    end else begin
      sh2_s = d1_r;
    end
    if (a2_r) begin
      sh3_s = {d2_r[14:0], 1'b0};
    end else begin
      sh3_s = d2_r;
    end
  end

`ifdef BARREL_SHL_OVF_EN
  // Sticky overflow: OR in whatever bits each stage pushes past bit 15.
  always_comb begin
    ovf0_s = bus.in_amt[3] & (|bus.in_data[15:8]);
    ovf1_s = ovf0_r | (a0_r[2] & (|d0_r[15:12]));
    ovf2_s = ovf1_r | (a1_r[1] & (|d1_r[15:14]));
    ovf3_s = ovf2_r | (a2_r & d2_r[15]);
  end
`endif

  // Valid bits (and overflow flags) always reset; a ready stage takes its predecessor's valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v0_r <= 1'b0;
      v1_r <= 1'b0;
      v2_r <= 1'b0;
      v3_r <= 1'b0;
`ifdef BARREL_SHL_OVF_EN
      ovf0_r <= 1'b0;
      ovf1_r <= 1'b0;
      ovf2_r <= 1'b0;
      ovf3_r <= 1'b0;
`endif
    end else begin
      if (rdy0_s) begin
        v0_r <= bus.in_valid;
      end
      if (rdy1_s) begin
        v1_r <= v0_r;
      end
      if (rdy2_s) begin
        v2_r <= v1_r;
      end
      if (rdy3_s) begin
        v3_r <= v2_r;
      end
`ifdef BARREL_SHL_OVF_EN
      if (rdy0_s && bus.in_valid) begin
        ovf0_r <= ovf0_s;
      end
      if (rdy1_s && v0_r) begin
        ovf1_r <= ovf1_s;
      end
      if (rdy2_s && v1_r) begin
        ovf2_r <= ovf2_s;
      end
      if (rdy3_s && v2_r) begin
        ovf3_r <= ovf3_s;
      end
`endif
    end
  end

  // Data/amount registers load only with a valid predecessor; bubbles leave them untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      if (STAGE_RST_DATA) begin
        d0_r <= '0;
        d1_r <= '0;
        d2_r <= '0;
        d3_r <= '0;
        a0_r <= 3'b000;
        a1_r <= 2'b00;
        a2_r <= 1'b0;
      end
    end else begin
      if (rdy0_s && bus.in_valid) begin
        d0_r <= sh0_s;
        a0_r <= bus.in_amt[2:0];
      end
      if (rdy1_s && v0_r) begin
        d1_r <= sh1_s;
        a1_r <= a0_r[1:0];
      end
      if (rdy2_s && v1_r) begin
        d2_r <= sh2_s;
        a2_r <= a1_r[0];
      end
      if (rdy3_s && v2_r) begin
        d3_r <= sh3_s;
      end
    end
  end

  assign bus.in_ready  = rdy0_s;
  assign bus.out_valid = v3_r;
  assign bus.out_data  = d3_r;
`ifdef BARREL_SHL_OVF_EN
  assign bus.out_ovf   = ovf3_r;
`endif

endmodule

// File: tb/tb_barrel_shl_pipe_16bit.sv
// Directed bench for barrel_shl_pipe_16bit: reset, latency, streaming, backpressure, bubbles, overflow.
module tb_barrel_shl_pipe_16bit;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_fail;
  logic [16:0] nxt_exp;
  logic        last_acc;
  logic [16:0] exp_q[$];

  barrel_shl_pipe_16bit_if bus ();

  barrel_shl_pipe_16bit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // {ovf, data} of a 16-bit left shift
  function automatic logic [16:0] model(input logic [15:0] d, input logic [3:0] a);
    logic [31:0] t;
    t = {16'h0000, d} << a;
    return {|t[31:16], t[15:0]};
  endfunction

  task automatic drive(input logic v, input logic [15:0] d, input logic [3:0] a, input logic [16:0] e);
    bus.in_valid = v;
    bus.in_data  = d;
    bus.in_amt   = a;
    nxt_exp      = e;
  endtask

  // Called just after a falling edge: record handshakes, check outputs, advance one cycle.
  task automatic step();
    logic [16:0] e;
    #1;
    last_acc = bus.in_valid && bus.in_ready;
    if (last_acc) exp_q.push_back(nxt_exp);
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        chk("sb_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("sb_data", {16'h0000, bus.out_data}, {16'h0000, e[15:0]});
`ifdef BARREL_SHL_OVF_EN
        chk("sb_ovf", {31'd0, bus.out_ovf}, {31'd0, e[16]});
`endif
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) step();
    chk(tag, 32'(exp_q.size()), 32'd0);
    chk({tag, "_ov"}, {31'd0, bus.out_valid}, 32'd0);
  endtask

  initial begin
    logic [15:0] strm_tab [0:15];
    logic [15:0] hold_d;
    logic        have_d;
    logic        cur_v;
    logic [15:0] bd;
    logic [3:0]  ba;
    int          j;
    int          cyc;

    strm_tab = '{16'hA5C3, 16'h4B86, 16'h970C, 16'h2E18, 16'h5C30, 16'hB860, 16'h70C0, 16'hE180,
                 16'hC300, 16'h8600, 16'h0C00, 16'h1800, 16'h3000, 16'h6000, 16'hC000, 16'h8000};
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b1;
    bus.out_ready = 1'b1;
    drive(1'b0, 16'h0000, 4'd0, 17'h00000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // Single shift: presented in one cycle, visible four cycles later
    drive(1'b1, 16'h0001, 4'd15, {1'b0, 16'h8000});
    step();
    chk("single_acc", {31'd0, last_acc}, 32'd1);
    drive(1'b0, 16'h0000, 4'd0, 17'h00000);
    for (int i = 0; i < 3; i++) begin
      chk("single_early", {31'd0, bus.out_valid}, 32'd0);
      step();
    end
    chk("single_lat", {31'd0, bus.out_valid}, 32'd1);
    drain("single_drain");

    // Streaming 0xA5C3 << 0..15 back to back
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 16'hA5C3, 4'(i), {(i != 0), strm_tab[i]});
      chk("strm_in_ready", {31'd0, bus.in_ready}, 32'd1);
      if (i >= 4) chk("strm_out_valid", {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    drive(1'b0, 16'h0000, 4'd0, 17'h00000);
    for (int i = 0; i < 4; i++) begin
      chk("strm_tail_valid", {31'd0, bus.out_valid}, 32'd1);
      step();
    end
    chk("strm_done", {31'd0, bus.out_valid}, 32'd0);
    chk("strm_empty", 32'(exp_q.size()), 32'd0);

    // Reset with three requests in flight
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'h0101 + 16'(i), 4'(i + 1), model(16'h0101 + 16'(i), 4'(i + 1)));
      step();
    end
    drive(1'b0, 16'h0000, 4'd0, 17'h00000);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      chk("midrst_no_out", {31'd0, bus.out_valid}, 32'd0);
      step();
    end

    // Backpressure: six stalled cycles, then release
    bus.out_ready = 1'b0;
    j = 0;
    have_d = 1'b0;
    hold_d = 16'h0000;
    for (int c = 0; c < 6; c++) begin
      drive(1'b1, 16'h1234 + 16'(j), 4'(j + 2), model(16'h1234 + 16'(j), 4'(j + 2)));
      step();
      if (last_acc) j++;
      if (bus.out_valid) begin
        if (!have_d) begin
          hold_d = bus.out_data;
          have_d = 1'b1;
        end else begin
          chk("bp_stable", {16'h0000, bus.out_data}, {16'h0000, hold_d});
        end
      end
    end
    chk("bp_accepted", 32'(j), 32'd4);
    chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
    bus.out_ready = 1'b1;
    for (int c = 0; c < 40 && j < 8; c++) begin
      drive(1'b1, 16'h1234 + 16'(j), 4'(j + 2), model(16'h1234 + 16'(j), 4'(j + 2)));
      step();
      if (last_acc) j++;
    end
    chk("bp_total", 32'(j), 32'd8);
    drain("bp_drain");

    // Bubbles with random downstream stalls
    j = 0;
    cyc = 0;
    cur_v = 1'b1;
    bd = 16'($urandom);
    ba = 4'($urandom_range(0, 15));
    while (j < 200 && cyc < 5000) begin
      bus.out_ready = 1'($urandom_range(0, 1));
      drive(cur_v, bd, ba, model(bd, ba));
      step();
      cyc++;
      if (cur_v) begin
        if (last_acc) begin
          j++;
          cur_v = 1'b0;
          bd = 16'($urandom);
          ba = 4'($urandom_range(0, 15));
        end
      end else begin
        cur_v = 1'b1;
      end
    end
    chk("bub_count", 32'(j), 32'd200);
    drain("bub_drain");

`ifdef BARREL_SHL_OVF_EN
    drive(1'b1, 16'h8000, 4'd1, {1'b1, 16'h0000});
    step();
    drive(1'b1, 16'h00FF, 4'd8, {1'b0, 16'hFF00});
    step();
    drain("ovf_drain");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
